// File: rtl/approx_mul_pkg.sv
// Shared widths, compensation weights and pipeline-stage layout for the approximate multiplier scheduler.
// Used by both the combinational core and the arbitration/pipeline wrapper.
package approx_mul_pkg;

  localparam int X_W   = 8;
  localparam int Z_W   = 16;
  localparam int N_REQ = 2;

  // Weights of the compensation terms added on top of the truncated partial-product sum.
  localparam int unsigned COMP_W256  = 256;
  localparam int unsigned COMP_W512  = 512;
  localparam int unsigned COMP_W1024 = 1024;

  typedef logic req_id_t;

  typedef struct packed {
    logic           valid;
    req_id_t        id;
    logic [X_W-1:0] x;
    logic [X_W-1:0] y;
    logic           exact;
  } stage_t;

endpackage

// File: rtl/approx_mul8_core.sv
// 8x8 unsigned multiplier with an exact mode and an approximate mode (upper-nibble rows plus carry compensation).
// Purely combinational, no handshake; the caller registers inputs and result.
module approx_mul8_core
  import approx_mul_pkg::*;
(
  input  logic [X_W-1:0] x,
  input  logic [X_W-1:0] y,
  input  logic           exact,
  output logic [Z_W-1:0] z
);

  logic [Z_W-1:0] z_exact;
  logic [Z_W-1:0] z_rows;
  logic [Z_W-1:0] z_comp;
  logic [2:0]     n256;
  logic [1:0]     n512;
  logic           n1024;

  // Lower-nibble partial-product bits that still feed the compensation network.
  logic a07, a16, a17, a26, a34, a25, a35, a27, a36, a37;

  assign a07 = x[0] & y[7];
  assign a16 = x[1] & y[6];
  assign a17 = x[1] & y[7];
  assign a26 = x[2] & y[6];
  assign a34 = x[3] & y[4];
  assign a25 = x[2] & y[5];
  assign a35 = x[3] & y[5];
  assign a27 = x[2] & y[7];
  assign a36 = x[3] & y[6];
  assign a37 = x[3] & y[7];

  assign z_exact = Z_W'(x) * Z_W'(y);
  assign z_rows  = (Z_W'(y) * Z_W'(x[X_W-1:4])) << 4;

  assign n256  = 3'(a07 | a16) + 3'(a17) + 3'(a26 | a34) + 3'(a25 & a35) + 3'(a25 | a35);
  assign n512  = 2'(a27 & a36) + 2'(a27 | a36);
  assign n1024 = a37;

  assign z_comp = Z_W'(n256 * COMP_W256 + n512 * COMP_W512 + n1024 * COMP_W1024);

  assign z = exact ? z_exact : (z_rows + z_comp);

endmodule

// File: rtl/approx_mul_sched.sv
// Two-requester round-robin front end for one shared approx/exact multiplier; accept->response latency 2 edges.
// One outstanding request per requester; responses are held until their handshake, which also gates new accepts.
module approx_mul_sched
  import approx_mul_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [X_W-1:0] req0_x,
  input  logic [X_W-1:0] req0_y,
  input  logic           req0_exact,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [X_W-1:0] req1_x,
  input  logic [X_W-1:0] req1_y,
  input  logic           req1_exact,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [Z_W-1:0] rsp0_z,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [Z_W-1:0] rsp1_z,
  output logic           busy
);

  logic [N_REQ-1:0]          req_vld;
  logic [N_REQ-1:0]          rsp_rdy;
  logic [N_REQ-1:0]          outstanding;
  logic [N_REQ-1:0]          eligible;
  logic [N_REQ-1:0]          grant;
  logic [N_REQ-1:0]          req_rdy;
  logic [N_REQ-1:0]          accept;
  logic [N_REQ-1:0]          rsp_vld_q;
  logic [N_REQ-1:0]          rsp_hs;
  logic [N_REQ-1:0][Z_W-1:0] rsp_z_q;
  req_id_t                   prio_q;
  req_id_t                   acc_id;
  stage_t                    s1_d;
  stage_t                    s1_q;
  stage_t                    s2_q;
  logic [Z_W-1:0]            core_z;

  assign req_vld  = {req1_valid, req0_valid};
  assign rsp_rdy  = {rsp1_ready, rsp0_ready};
  assign eligible = req_vld & ~outstanding;

  // Each grant looks only at the other requester's request, so a ready never
  // depends on its own valid; the two grants can never both accept.
  assign grant[0] = (prio_q == 1'b0) || !eligible[1];
  assign grant[1] = (prio_q == 1'b1) || !eligible[0];

  // Nothing is acceptable while the registers are held in reset.
  assign req_rdy = grant & ~outstanding & {N_REQ{rst_n}};
  assign accept  = req_vld & req_rdy;
  assign rsp_hs  = rsp_vld_q & rsp_rdy;
  assign acc_id  = req_id_t'(accept[1]);

  always_comb begin
    s1_d       = '0;
    s1_d.valid = |accept;
    s1_d.id    = acc_id;
    if (acc_id == 1'b1) begin
      s1_d.x     = req1_x;
      s1_d.y     = req1_y;
      s1_d.exact = req1_exact;
    end else begin
      s1_d.x     = req0_x;
      s1_d.y     = req0_y;
      s1_d.exact = req0_exact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      prio_q      <= RR_INIT;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      outstanding <= (outstanding | accept) & ~rsp_hs;
      if (|accept) begin
        prio_q <= ~acc_id;
      end
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  approx_mul8_core u_core (
    .x     (s2_q.x),
    .y     (s2_q.y),
    .exact (s2_q.exact),
    .z     (core_z)
  );

  // A response slot is never written while still full: its owner cannot
  // have a second request in flight until the slot has been consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      rsp_z_q   <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (s2_q.valid && (s2_q.id == r[0])) begin
          rsp_vld_q[r] <= 1'b1;
          rsp_z_q[r]   <= core_z;
        end else if (rsp_hs[r]) begin
          rsp_vld_q[r] <= 1'b0;
        end
      end
    end
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];
  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp0_z     = rsp_z_q[0];
  assign rsp1_z     = rsp_z_q[1];
  assign busy       = |outstanding;

endmodule

// File: tb/tb_approx_mul_sched.sv
// Directed and scoreboarded checks of the two-requester approximate multiplier scheduler.
// Inputs change and outputs are sampled 2-3 time units after each rising edge.
module tb_approx_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_exact;
  logic        req1_valid, req1_ready, req1_exact;
  logic [7:0]  req0_x, req0_y, req1_x, req1_y;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_z, rsp1_z;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  bit          pend0, pend1;
  int          n_rnd_acc;

  always #5 clk = ~clk;

  approx_mul_sched #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_exact (req0_exact),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_exact (req1_exact),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_z     (rsp0_z),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_z     (rsp1_z),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_exact = 1'b0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_exact = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic e);
    int s;
    int c256;
    int c512;
    if (e) return 16'(int'(x) * int'(y));
    s    = int'(y) * int'(x[7:4]) * 16;
    c256 = int'(x[0] & y[7] | x[1] & y[6]) + int'(x[1] & y[7]) + int'(x[2] & y[6] | x[3] & y[4])
         + int'(x[2] & y[5] & x[3] & y[5]) + int'(x[2] & y[5] | x[3] & y[5]);
    c512 = int'(x[2] & y[7] & x[3] & y[6]) + int'(x[2] & y[7] | x[3] & y[6]);
    s    = s + 256 * c256 + 512 * c512 + 1024 * int'(x[3] & y[7]);
    return s[15:0];
  endfunction

  task automatic sb_step;
    logic a0, a1;
    settle();
    check("rnd_busy", busy, (exp0.size() != 0) || (exp1.size() != 0));
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    check("rnd_one_acc", a0 & a1, 0);
    if (rsp0_valid && rsp0_ready) begin
      check("rnd_q0_nonempty", exp0.size() != 0, 1);
      if (exp0.size() != 0) check("rnd_z0", rsp0_z, exp0.pop_front());
    end
    if (rsp1_valid && rsp1_ready) begin
      check("rnd_q1_nonempty", exp1.size() != 0, 1);
      if (exp1.size() != 0) check("rnd_z1", rsp1_z, exp1.pop_front());
    end
    if (a0) begin exp0.push_back(model(req0_x, req0_y, req0_exact)); n_rnd_acc++; end
    if (a1) begin exp1.push_back(model(req1_x, req1_y, req1_exact)); n_rnd_acc++; end
    pend0 = req0_valid && !req0_ready;
    pend1 = req1_valid && !req1_ready;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int acc_cyc[$];
    int n_hs0, n_hs1;
    bit both_ev;
    logic a0, a1;

    // Reset state, with requests already asserted.
    rst_n = 1'b0;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp0_vld", rsp0_valid, 0);
    check("rst_rsp1_vld", rsp1_valid, 0);
    check("rst_rsp0_z", rsp0_z, 16'h0000);
    check("rst_rsp1_z", rsp1_z, 16'h0000);

    // Approximate 0x0F*0xFF, accepted on the first edge after reset release.
    req1_valid = 1'b0;
    req0_x = 8'h0F; req0_y = 8'hFF; req0_exact = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("first_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_rdy0_low", req0_ready, 0);
    check("lat_n0", rsp0_valid, 0);
    tick();
    check("lat_n1", rsp0_valid, 0);
    tick();
    check("lat_n2", rsp0_valid, 1);
    check("approx_z", rsp0_z, 16'h0D00);
    tick();
    check("hold_vld", rsp0_valid, 1);
    check("hold_z", rsp0_z, 16'h0D00);
    rsp0_ready = 1'b1;
    settle();
    check("hs_cycle_rdy0", req0_ready, 0);
    tick();
    check("after_hs_vld", rsp0_valid, 0);
    check("after_hs_busy", busy, 0);
    check("after_hs_rdy0", req0_ready, 1);

    // Same operands, exact mode.
    req0_exact = 1'b1;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("exact_vld", rsp0_valid, 1);
    check("exact_z", rsp0_z, 16'h0EF1);
    tick();
    check("exact_consumed", rsp0_valid, 0);

    // Both requesters always valid: grants alternate, starting with requester 0.
    do_reset();
    req0_valid = 1'b1; req0_x = 8'h10; req0_y = 8'h10; req0_exact = 1'b1;
    req1_valid = 1'b1; req1_x = 8'hF0; req1_y = 8'hFF; req1_exact = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n_hs0 = 0; n_hs1 = 0; both_ev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      settle();
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      check("alt_one_acc", a0 & a1, 0);
      if (a0) begin order.push_back(0); acc_cyc.push_back(c); end
      if (a1) begin order.push_back(1); acc_cyc.push_back(c); end
      if (rsp0_valid && rsp0_ready) begin n_hs0++; check("alt_z0", rsp0_z, 16'h0100); end
      if (rsp1_valid && rsp1_ready) begin
        n_hs1++;
        check("alt_z1", rsp1_z, 16'hEF10);
        if (a0) both_ev = 1'b1;
      end
      tick();
    end
    check("alt_n_acc", order.size(), 6);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) check("alt_order", order[i], i % 2);
    end
    if (acc_cyc.size() >= 2) check("alt_back_to_back", acc_cyc[1] - acc_cyc[0], 1);
    check("alt_n_hs0", n_hs0, 3);
    check("alt_n_hs1", n_hs1, 2);
    check("alt_hs1_with_acc0", both_ev, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) tick();

    // Requester 0 response back-pressured; requester 1 keeps being served.
    do_reset();
    req0_valid = 1'b1; req0_x = 8'h03; req0_y = 8'h05; req0_exact = 1'b1;
    req1_valid = 1'b1; req1_x = 8'h12; req1_y = 8'h34; req1_exact = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    settle();
    check("bp_rdy0_first", req0_ready, 1);
    check("bp_rdy1_first", req1_ready, 0);
    tick();
    n_hs1 = 0;
    for (int c = 1; c <= 8; c++) begin
      settle();
      check("bp_rdy0", req0_ready, 0);
      if (c >= 3) begin
        check("bp_rsp0_vld", rsp0_valid, 1);
        check("bp_rsp0_z", rsp0_z, 16'h000F);
      end
      if (rsp1_valid && rsp1_ready) begin
        n_hs1++;
        check("bp_z1", rsp1_z, 16'h03A8);
      end
      tick();
    end
    check("bp_n_hs1", n_hs1, 2);
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    settle();
    check("bp_hs_cycle_rdy0", req0_ready, 0);
    tick();
    check("bp_after_hs_vld", rsp0_valid, 0);
    check("bp_after_hs_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("bp_second_vld", rsp0_valid, 1);
    check("bp_second_z", rsp0_z, 16'h000F);
    tick();
    check("bp_second_consumed", rsp0_valid, 0);
    check("bp_idle_busy", busy, 0);

    // Reset one cycle after an accept discards the request.
    do_reset();
    req0_valid = 1'b1; req0_x = 8'h22; req0_y = 8'h33; req0_exact = 1'b1;
    tick();
    req0_valid = 1'b0;
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    settle();
    check("mid_busy_async", busy, 0);
    check("mid_rdy0_async", req0_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("mid_no_rsp0", rsp0_valid, 0);
      check("mid_no_rsp1", rsp1_valid, 0);
      check("mid_busy", busy, 0);
      tick();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    check("mid_prio_rdy0", req0_ready, 1);
    check("mid_prio_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Random operands, both modes, random request and response back-pressure.
    do_reset();
    pend0 = 1'b0; pend1 = 1'b0; n_rnd_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_x     = 8'($urandom);
        req0_y     = 8'($urandom);
        req0_exact = 1'($urandom_range(0, 1));
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_x     = 8'($urandom);
        req1_y     = 8'($urandom);
        req1_exact = 1'($urandom_range(0, 1));
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      sb_step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb_step();
    check("rnd_q0_drained", exp0.size(), 0);
    check("rnd_q1_drained", exp1.size(), 0);
    check("rnd_activity", n_rnd_acc > 500, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
